// File: rtl/shift_add_mult_ctrl.sv
// Iterative unsigned shift-add multiplier sequencer: one add/shift per clock
// on a shared WIDTH-bit adder, WIDTH iterations per operand pair.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count;

  // Adder result and the shifted accumulator it produces this iteration.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] p_hi_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  always_comb begin
    sum = {1'b0, p_hi};
    if (q_reg[0]) begin
      sum = {1'b0, p_hi} + {1'b0, a_reg};
    end
    // The carry enters the MSB, so no bit of the partial sum is lost.
    p_hi_nxt  = sum[WIDTH:1];
    q_nxt     = {sum[0], q_reg[WIDTH-1:1]};
    last_iter = (count == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE_ST;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE_ST: done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      p_hi    <= '0;
      q_reg   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= multiplicand;
            q_reg <= multiplier;
            p_hi  <= '0;
            count <= '0;
          end
        end
        RUN: begin
          p_hi  <= p_hi_nxt;
          q_reg <= q_nxt;
          count <= count + 1'b1;
          if (last_iter) begin
            product <= {p_hi_nxt, q_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl (WIDTH=8): hand-computed products,
// latency, START-while-busy handling and asynchronous reset.
module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        ready, busy, done;
  logic [15:0] product;

  int vectors = 0;
  int miscompares = 0;
  int lat, busy_n, done_n;

  shift_add_mult_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair for a single cycle; returns at the first
  // falling edge after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles after acceptance until DONE, bounded by a cycle budget.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1;
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    @(negedge clk);
    reset = 1'b1;

    // 13 * 11
    start_op(8'd13, 8'd11);
    multiplicand = 8'hAA;
    multiplier = 8'h55;
    wait_done(lat, busy_n);
    check("basic_latency", lat, 8);
    check("basic_busy_cycles", busy_n, 8);
    check("basic_product", product, 16'h008F);
    @(negedge clk);
    check("basic_done_pulse", done, 0);
    check("basic_ready_after", ready, 1);
    check("basic_product_hold", product, 16'h008F);

    // 255 * 255 exercises the carry out of every add
    start_op(8'd255, 8'd255);
    wait_done(lat, busy_n);
    check("carry_latency", lat, 8);
    check("carry_product", product, 16'hFE01);

    // Zero multiplicand still takes the full latency
    start_op(8'd0, 8'd200);
    wait_done(lat, busy_n);
    check("zero_latency", lat, 8);
    check("zero_product", product, 0);

    // 7 * 9 with START raised during RUN and held through DONE
    start_op(8'd7, 8'd9);
    start = 1'b1;
    multiplicand = 8'd3;
    multiplier = 8'd3;
    wait_done(lat, busy_n);
    check("ignore_latency", lat, 8);
    check("ignore_product", product, 63);
    @(negedge clk);
    check("held_ready", ready, 1);
    check("held_done_low", done, 0);
    @(negedge clk);
    start = 1'b0;
    check("held_accepted", busy, 1);
    wait_done(lat, busy_n);
    check("held_latency", lat, 8);
    check("held_product", product, 9);

    // 100 * 100 aborted by reset in RUN cycle 4
    start_op(8'd100, 8'd100);
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    @(negedge clk);
    reset = 1'b1;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", done_n, 0);
    check("abort_product_hold", product, 0);

    start_op(8'd2, 8'd3);
    wait_done(lat, busy_n);
    check("post_reset_latency", lat, 8);
    check("post_reset_product", product, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
